text_tile_renderer: RTL

//  Text-mode overlay for the video pipeline. Holds a COLS x ROWS character buffer.

---
 rtl/text_tile_renderer_pkg.sv | 16 +
 rtl/text_tile_renderer_if.sv | 24 ++
 rtl/text_tile_renderer_glyph_rom_5x8.sv | 63 ++++++
 rtl/text_tile_renderer.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/text_tile_renderer_pkg.sv
// Shared constants and FSM encoding for the text tile renderer.
// Pure declarations, no timing; nothing to backpressure.
// Glyph codes: 0..25 = A..Z, 26 = marker, 27 = blank, >= 28 render blank.
package text_tile_renderer_pkg;
    localparam int CELL_W      = 8;
    localparam int CELL_H      = 8;
    localparam int GLYPH_W     = 5;
    localparam int GLYPH_COUNT = 28;
    localparam int CHAR_BLANK  = 27;
    localparam int CHAR_MARK   = 26;

    typedef enum logic {
        ST_IDLE,
        ST_CLEAR
    } state_t;
endpackage

// File: rtl/text_tile_renderer_if.sv
// Character write port and clear control of the text tile renderer.
// Combinational handshake; the write is accepted on wr_valid && wr_ready.
// wr_ready drops for the whole clear, so the writer must hold its request.
interface text_tile_renderer_if #(
    parameter int CHAR_W = 5
);
    logic              wr_valid;
    logic              wr_ready;
    logic [4:0]        wr_col;
    logic [4:0]        wr_row;
    logic [CHAR_W-1:0] wr_char;
    logic              clear_req;
    logic              busy;

    modport master (
        output wr_valid, wr_col, wr_row, wr_char, clear_req,
        input  wr_ready, busy
    );

    modport slave (
        input  wr_valid, wr_col, wr_row, wr_char, clear_req,
        output wr_ready, busy
    );
endinterface

// File: rtl/text_tile_renderer_glyph_rom_5x8.sv
// Registered 5x8 font ROM: {char, y} -> glyph row, bit 0 = leftmost pixel.
// Latency 1 clk.
// Free-running, never stalls.
module text_tile_renderer_glyph_rom_5x8
    import text_tile_renderer_pkg::*;
#(
    parameter int CHAR_W = 5
) (
    input  logic               clk,
    input  logic [CHAR_W-1:0]  char_code,
    input  logic [2:0]         y,
    output logic [GLYPH_W-1:0] row
);
    // Each glyph is written top row first, leftmost pixel as the MSB of each 5-bit group.
    function automatic logic [39:0] font(input int code);
        logic [39:0] f;
        if (code >= GLYPH_COUNT || code == CHAR_BLANK) begin
            f = '0;
        end else begin
            case (code)
                0:  f = 40'b00100_01010_10001_10001_11111_10001_10001_00000;
                1:  f = 40'b11110_10001_10001_11110_10001_10001_11110_00000;
                2:  f = 40'b01110_10001_10000_10000_10000_10001_01110_00000;
                3:  f = 40'b11110_10001_10001_10001_10001_10001_11110_00000;
                4:  f = 40'b11111_10000_10000_11110_10000_10000_11111_00000;
                5:  f = 40'b11111_10000_10000_11110_10000_10000_10000_00000;
                6:  f = 40'b01110_10001_10000_10111_10001_10001_01111_00000;
                7:  f = 40'b10001_10001_10001_11111_10001_10001_10001_00000;
                8:  f = 40'b01110_00100_00100_00100_00100_00100_01110_00000;
                9:  f = 40'b00111_00010_00010_00010_00010_10010_01100_00000;
                10: f = 40'b10001_10010_10100_11000_10100_10010_10001_00000;
                11: f = 40'b10000_10000_10000_10000_10000_10000_11111_00000;
                12: f = 40'b10001_11011_10101_10101_10001_10001_10001_00000;
                13: f = 40'b10001_10001_11001_10101_10011_10001_10001_00000;
                14: f = 40'b01110_10001_10001_10001_10001_10001_01110_00000;
                15: f = 40'b11110_10001_10001_11110_10000_10000_10000_00000;
                16: f = 40'b01110_10001_10001_10001_10101_10010_01101_00000;
                17: f = 40'b11110_10001_10001_11110_10100_10010_10001_00000;
                18: f = 40'b01111_10000_10000_01110_00001_00001_11110_00000;
                19: f = 40'b11111_00100_00100_00100_00100_00100_00100_00000;
                20: f = 40'b10001_10001_10001_10001_10001_10001_01110_00000;
                21: f = 40'b10001_10001_10001_10001_10001_01010_00100_00000;
                22: f = 40'b10001_10001_10001_10101_10101_10101_01010_00000;
                23: f = 40'b10001_10001_01010_00100_01010_10001_10001_00000;
                24: f = 40'b10001_10001_01010_00100_00100_00100_00100_00000;
                25: f = 40'b11111_00001_00010_00100_01000_10000_11111_00000;
                CHAR_MARK: f = '1;
                default:   f = '0;
            endcase
        end
        return f;
    endfunction

    logic [GLYPH_W-1:0] vis;

    assign vis = GLYPH_W'(font(int'(char_code)) >> (GLYPH_W * (7 - int'(y))));

    always_ff @(posedge clk) begin
        for (int i = 0; i < GLYPH_W; i++) begin
            row[i] <= vis[GLYPH_W-1-i];
        end
    end
endmodule

// File: rtl/text_tile_renderer.sv
// Text overlay: COLS x ROWS character buffer rendered through a 5x8 font, one pixel per clk.
// Latency 3 clk from hpos/vpos/display_on to pixel_out/pixel_valid; rendering never stalls.
// Writes backpressured only while a clear runs. CURSOR_BLINK_EN adds the blinking cursor.
module text_tile_renderer
    import text_tile_renderer_pkg::*;
#(
    parameter int COLS         = 32,
    parameter int ROWS         = 30,
    parameter int POS_W        = 9,
    parameter int CHAR_W       = 5,
    parameter int BLINK_FRAMES = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [POS_W-1:0] hpos,
    input  logic [POS_W-1:0] vpos,
    input  logic             display_on,
    input  logic             frame_start,
    input  logic [4:0]       cursor_col,
    input  logic [4:0]       cursor_row,
    output logic             pixel_out,
    output logic             pixel_valid,
    text_tile_renderer_if.slave wr
);
    localparam int CELLS = COLS * ROWS;
    localparam int AW    = $clog2(CELLS);
    localparam int XB    = $clog2(CELL_W);
    localparam int YB    = $clog2(CELL_H);
    localparam int CW    = POS_W - XB;
    localparam int RW    = POS_W - YB;

    state_t            state;
    logic [AW-1:0]     clr_cnt;
    logic              busy_q;
    logic [CHAR_W-1:0] ram [CELLS];
    logic              we;
    logic [AW-1:0]     waddr;
    logic [CHAR_W-1:0] wdata;
    logic              wr_in_range;

    assign wr.wr_ready  = (state == ST_IDLE) && !reset;
    assign wr.busy      = busy_q;
    assign wr_in_range  = (int'(wr.wr_col) < COLS) && (int'(wr.wr_row) < ROWS);

    // Clear owns the single write port; out-of-range user writes complete the handshake but never reach RAM.
    always_comb begin
        we    = 1'b0;
        waddr = clr_cnt;
        wdata = CHAR_W'(CHAR_BLANK);
        if (!reset && state == ST_CLEAR) begin
            we = 1'b1;
        end else if (wr.wr_valid && wr.wr_ready && wr_in_range) begin
            we    = 1'b1;
            waddr = AW'(wr.wr_row) * AW'(COLS) + AW'(wr.wr_col);
            wdata = wr.wr_char;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_IDLE;
            clr_cnt <= '0;
            busy_q  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (wr.clear_req) begin
                        state   <= ST_CLEAR;
                        busy_q  <= 1'b1;
                        clr_cnt <= '0;
                    end
                end
                ST_CLEAR: begin
                    if (clr_cnt == AW'(CELLS - 1)) begin
                        state   <= ST_IDLE;
                        busy_q  <= 1'b0;
                        clr_cnt <= '0;
                    end else begin
                        clr_cnt <= clr_cnt + AW'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    logic [CW-1:0]     cell_col;
    logic [RW-1:0]     cell_row;
    logic              cell_in_range;
    logic [AW-1:0]     raddr;
    logic [CHAR_W-1:0] rd_char;
    logic              cur_hit;

    assign cell_col      = hpos[POS_W-1:XB];
    assign cell_row      = vpos[POS_W-1:YB];
    assign cell_in_range = (int'(cell_col) < COLS) && (int'(cell_row) < ROWS);
    assign raddr         = cell_in_range ? AW'(cell_row) * AW'(COLS) + AW'(cell_col) : '0;

    // Read and write share the edge, so a same-cell read returns the pre-write character.
    always_ff @(posedge clk) begin
        if (we) begin
            ram[waddr] <= wdata;
        end
        rd_char <= ram[raddr];
    end

`ifdef CURSOR_BLINK_EN
    localparam int FW = $clog2(BLINK_FRAMES) + 1;

    logic [FW-1:0] frame_cnt;
    logic          blink;

    always_ff @(posedge clk) begin
        if (reset) begin
            frame_cnt <= '0;
            blink     <= 1'b0;
        end else if (frame_start) begin
            if (frame_cnt == FW'(BLINK_FRAMES - 1)) begin
                frame_cnt <= '0;
                blink     <= ~blink;
            end else begin
                frame_cnt <= frame_cnt + FW'(1);
            end
        end
    end

    assign cur_hit = blink && display_on &&
                     (cell_col == CW'(cursor_col)) && (cell_row == RW'(cursor_row));
`else
    logic unused_cursor;

    assign cur_hit       = 1'b0;
    assign unused_cursor = ^{cursor_col, cursor_row, frame_start, (BLINK_FRAMES > 0)};
`endif

    logic [2:0]         s1_x, s2_x;
    logic [2:0]         s1_y;
    logic               s1_blank, s2_blank;
    logic               s1_vld, s2_vld;
    logic               s1_cur, s2_cur;
    logic [GLYPH_W-1:0] glyph_row;
    logic [CELL_W-1:0]  glyph_ext;

    text_tile_renderer_glyph_rom_5x8 #(
        .CHAR_W (CHAR_W)
    ) u_rom (
        .clk       (clk),
        .char_code (rd_char),
        .y         (s1_y),
        .row       (glyph_row)
    );

    // Columns 5..7 of every cell land on the zero-extended bits.
    assign glyph_ext = CELL_W'(glyph_row);

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_vld      <= 1'b0;
            s2_vld      <= 1'b0;
            s1_cur      <= 1'b0;
            s2_cur      <= 1'b0;
            s1_blank    <= 1'b1;
            s2_blank    <= 1'b1;
            s1_x        <= '0;
            s1_y        <= '0;
            s2_x        <= '0;
            pixel_out   <= 1'b0;
            pixel_valid <= 1'b0;
        end else begin
            s1_vld      <= display_on;
            s1_cur      <= cur_hit;
            s1_blank    <= !cell_in_range;
            s1_x        <= hpos[2:0];
            s1_y        <= vpos[2:0];
            s2_vld      <= s1_vld;
            s2_cur      <= s1_cur;
            s2_blank    <= s1_blank;
            s2_x        <= s1_x;
            pixel_valid <= s2_vld;
            pixel_out   <= s2_vld && ((!s2_blank && glyph_ext[s2_x]) ^ s2_cur);
        end
    end
endmodule
